// File: rtl/alu_pkg.sv
// Shared definitions for the sequential Hack-style ALU: control-word bit
// positions and the controller state encoding.
package alu_pkg;

  // Bit positions inside ctrl = {zx, nx, zy, ny, f, no}
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_cond.sv
// Operand conditioning stage: optional zeroing followed by optional bitwise
// inversion, as used on both ALU inputs.
module alu_cond #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d,
  input  logic             z,
  input  logic             n,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] zeroed;

  assign zeroed = z ? '0 : d;
  assign q      = n ? ~zeroed : zeroed;

endmodule

// File: rtl/alu_seq.sv
// Hack-style ALU with a valid/ready handshake on both sides, single-cycle
// AND/ADD and an optional multi-cycle shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xc, yc;
  logic [WIDTH-1:0] sum, fn_res, single_res;
  logic             sum_cy, single_cy;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step, mul_res;
  logic             mul_no;
  logic             mul_sel, accept, last_iter;

  alu_cond #(.WIDTH(WIDTH)) u_cond_x (
    .d (x),
    .z (ctrl[CTRL_ZX]),
    .n (ctrl[CTRL_NX]),
    .q (xc)
  );

  alu_cond #(.WIDTH(WIDTH)) u_cond_y (
    .d (y),
    .z (ctrl[CTRL_ZY]),
    .n (ctrl[CTRL_NY]),
    .q (yc)
  );

  // With MUL_EN=0 this is constant 0, so the whole multiply path folds away.
  assign mul_sel   = (MUL_EN != 0) && mul;
  assign accept    = in_valid && in_ready;
  assign last_iter = (state == MUL) && (cnt == CW'(WIDTH - 1));

  // Single-cycle path: AND or ADD, carry taken before the output inversion.
  assign {sum_cy, sum} = {1'b0, xc} + {1'b0, yc};
  assign fn_res        = ctrl[CTRL_F] ? sum : (xc & yc);
  assign single_res    = ctrl[CTRL_NO] ? ~fn_res : fn_res;
  assign single_cy     = ctrl[CTRL_F] & sum_cy;

  // One shift-add step; the final step's sum is the product written out.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;
  assign mul_res  = mul_no ? ~acc_step : acc_step;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (accept && mul_sel) state_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (last_iter) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Multiply datapath: operands captured on accept, then shifted each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      mul_no <= 1'b0;
    end else if (accept && mul_sel) begin
      cnt    <= '0;
      mcand  <= xc;
      mplier <= yc;
      acc    <= '0;
      mul_no <= ctrl[CTRL_NO];
    end else if (state == MUL) begin
      cnt    <= last_iter ? '0 : cnt + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_step;
    end
  end

  // Result registers: a write always wins over a consumer pop on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      zr        <= 1'b1;
      ng        <= 1'b0;
      cy        <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept && !mul_sel) begin
      out       <= single_res;
      zr        <= (single_res == '0);
      ng        <= single_res[WIDTH-1];
      cy        <= single_cy;
      out_valid <= 1'b1;
    end else if (last_iter) begin
      out       <= mul_res;
      zr        <= (mul_res == '0);
      ng        <= mul_res[WIDTH-1];
      cy        <= 1'b0;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): an independent model predicts each
// accepted operation and a monitor compares results as they are consumed.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, y;
  logic [5:0]   ctrl;
  logic         mul;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zr, ng, cy;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
    logic         cy;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rand_ready = 1'b0;
  int   w0, w1, w2, w3;

  alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .mul       (mul),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .cy        (cy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [5:0] c, input logic m);
    logic [W-1:0]   xa, yb, r;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic           carry;
    xa = c[5] ? '0 : a;
    if (c[4]) xa = ~xa;
    yb = c[3] ? '0 : b;
    if (c[2]) yb = ~yb;
    carry = 1'b0;
    if (m) begin
      p = xa * yb;
      r = p[W-1:0];
    end else if (c[1]) begin
      s     = {1'b0, xa} + {1'b0, yb};
      r     = s[W-1:0];
      carry = s[W];
    end else begin
      r = xa & yb;
    end
    if (c[0]) r = ~r;
    model = '{out: r, zr: (r == '0), ng: r[W-1], cy: carry};
  endfunction

  // Drive one request; returns just after the accepting edge (or on timeout).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] c, input logic m, output int waits);
    @(negedge clk);
    x = a; y = b; ctrl = c; mul = m; in_valid = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("accept", in_ready, 1);
    if (in_ready) begin
      sb.push_back(model(a, b, c, m));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops on each consumed result and checks stability during stalls.
  logic         held_valid = 1'b0;
  logic [W+2:0] held;
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && !out_ready) begin
      if (held_valid) check("stall_hold", {out, zr, ng, cy}, held);
      held_valid = 1'b1;
      held       = {out, zr, ng, cy};
    end else begin
      held_valid = 1'b0;
    end
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {out, zr, ng, cy}, 0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("result", {out, zr, ng, cy}, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    int rdy_bad;
    int spurious;
    int wr;
    logic [5:0] rc;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; ctrl = '0; mul = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_flags", {zr, ng, cy}, 3'b100);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Directed single-cycle vectors
    issue(16'd5, 16'd3, 6'b000010, 1'b0, w0);
    check("add_latency_valid", out_valid, 1);
    check("add_5_3", {out, zr, ng, cy}, {16'd8, 3'b000});
    issue(16'd3, 16'd5, 6'b010011, 1'b0, w0);
    check("sub_3_5", {out, zr, ng}, {16'hFFFE, 2'b01});
    issue(16'hFFFF, 16'd1, 6'b000010, 1'b0, w0);
    check("add_wrap", {out, zr, cy}, {16'h0000, 2'b11});
    issue(16'h1234, 16'h5678, 6'b101010, 1'b0, w0);
    issue(16'h1234, 16'h5678, 6'b111111, 1'b0, w0);
    issue(16'h1234, 16'h5678, 6'b111010, 1'b0, w0);
    issue(16'h1234, 16'h5678, 6'b001100, 1'b0, w0);
    issue(16'hF0F0, 16'h3C3C, 6'b000000, 1'b0, w0);
    issue(16'hF0F0, 16'h3C3C, 6'b010101, 1'b0, w0);

    // Multiply 7*6: busy for exactly WIDTH cycles
    issue(16'd7, 16'd6, 6'b000010, 1'b1, w0);
    busy_cycles = 0;
    rdy_bad = 0;
    while (busy && busy_cycles < 100) begin
      if (in_ready) rdy_bad++;
      busy_cycles++;
      @(posedge clk);
      #1;
    end
    check("mul_busy_cycles", busy_cycles, W);
    check("mul_in_ready_low", rdy_bad, 0);
    check("mul_done_valid", out_valid, 1);
    check("mul_7_6", {out, zr, ng, cy}, {16'd42, 3'b000});
    issue(16'hFFFF, 16'hFFFF, 6'b000010, 1'b1, w0);
    issue(16'h0005, 16'h0003, 6'b010011, 1'b1, w0);
    repeat (20) @(posedge clk);

    // Back-to-back adds with the consumer stalled for 3 cycles
    repeat (2) @(posedge clk);
    #1;
    check("drained", out_valid, 0);
    fork
      begin
        issue(16'd10, 16'd20, 6'b000010, 1'b0, w0);
        issue(16'd11, 16'd21, 6'b000010, 1'b0, w1);
        issue(16'd12, 16'd22, 6'b000010, 1'b0, w2);
        issue(16'd13, 16'd23, 6'b000010, 1'b0, w3);
      end
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          #1;
          check("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    check("stall_wait_b", w1, 3);
    check("throughput_c", w2, 0);
    check("throughput_d", w3, 0);
    repeat (3) @(posedge clk);

    // Random mix with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rc = 6'($urandom_range(0, 63));
      issue(16'($urandom), 16'($urandom), rc, ($urandom_range(0, 3) == 0), wr);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("random_drained", sb.size(), 0);

    // Reset in the middle of a multiply
    issue(16'd9, 16'd11, 6'b000010, 1'b1, w0);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out", {out, zr}, {16'd0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) spurious++;
    end
    check("no_result_after_rst", spurious, 0);
    issue(16'd1, 16'd2, 6'b000010, 1'b0, w0);
    check("post_rst_add", out, 16'd3);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; legal range 4..64.
REQ-002 Parameter MUL_EN, default 1: 1 enables multi-cycle multiply mode; 0 removes the multiplier and ignores mul.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 x, y  input  WIDTH each  operands.
REQ-008 ctrl  input  6  {zx,nx,zy,ny,f,no}, MSB first, Hack ALU semantics.
REQ-009 mul  input  1  1 selects multiply (replaces the f function) when MUL_EN=1.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out  output  WIDTH  registered result.
REQ-013 zr, ng, cy  output  1 each  registered flags: out==0; out[WIDTH-1]; carry out of the add.
REQ-014 busy  output  1  high while in state MUL.

Function
REQ-015 Conditioning: xc = nx ? ~(zx ? 0 : x) : (zx ? 0 : x); yc is formed the same way from zy, ny, y.
REQ-016 Function: f=0 gives xc&yc; f=1 gives xc+yc modulo 2^WIDTH; multiply gives low WIDTH bits of xc*yc (unsigned); result inverted when no=1.
REQ-017 cy: carry out of bit WIDTH-1 of xc+yc when f=1 and mul=0; 0 otherwise; unaffected by no.
REQ-018 Accept occurs on a rising edge with in_valid && in_ready; inputs are sampled only then.
REQ-019 in_ready = (state==IDLE) && (!out_valid || out_ready); allows back-to-back single-cycle ops at full throughput.
REQ-020 States: IDLE, MUL. IDLE->MUL on accept with mul=1 and MUL_EN=1; MUL->IDLE after WIDTH iterations; all other accepts stay in IDLE.
REQ-021 Non-multiply latency: out, flags and out_valid=1 are updated on the accepting edge.
REQ-022 Multiply: one shift-add iteration per cycle in MUL, counter 0..WIDTH-1; out, flags and out_valid=1 written on the edge that completes iteration WIDTH-1 (WIDTH cycles after accept).
REQ-023 out_valid clears on an edge with out_ready=1 and no new result written that edge; if a result is written the same edge, out_valid stays 1.
REQ-024 While out_valid=1 and out_ready=0, out/zr/ng/cy are held stable.
REQ-025 out_ready is ignored while out_valid=0; in_valid is ignored while in_ready=0.

Reset
REQ-026 rst_n low asynchronously forces: state=IDLE, counter=0, out=0, zr=1, ng=0, cy=0, out_valid=0, busy=0.
REQ-027 Reset mid-multiply discards the operation; no result is produced after release.
REQ-028 in_ready=1 on the first edge after rst_n deasserts.

Structure
REQ-029 Shared package alu_pkg holds ctrl bit-index constants (CTRL_ZX..CTRL_NO) and the state encoding (IDLE, MUL).
REQ-030 One sub-module alu_cond (WIDTH-parametrised zero/negate stage), instantiated twice for x and y.
REQ-031 The multiplier is a shift-add datapath only; no combinational array multiplier.

Verification (WIDTH=16)
REQ-032 x=5, y=3, ctrl=000010, mul=0 -> out=8, zr=0, ng=0, cy=0, out_valid one edge after accept.
REQ-033 x=3, y=5, ctrl=010011 (x-y) -> out=0xFFFE, ng=1, zr=0.
REQ-034 x=0xFFFF, y=1, ctrl=000010 -> out=0, zr=1, cy=1.
REQ-035 x=7, y=6, ctrl=000010, mul=1 -> busy=1 and in_ready=0 for 16 cycles; then out=42, out_valid=1.
REQ-036 Back-to-back adds with out_ready held low 3 cycles -> out held and in_ready=0 during the stall; no result lost or duplicated; full throughput resumes.
REQ-037 rst_n pulsed low at multiply iteration 8 -> out_valid=0, busy=0 immediately; no result appears after release.
